// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a small byte FIFO feeding a baud-timed serializer.
// The tx line and every status field are driven directly from flops.
module uart_tx_mmio #(
    parameter int CLOCK_RATE = 12_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        clr_ovf,
    output logic [31:0] status,
    output logic        tx
);
    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int NW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   baud_r, baud_s;
    logic [2:0]      bit_r, bit_s;
    logic [7:0]      shift_r, shift_s;
    logic            tx_s;
    logic [7:0]      mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [NW-1:0]   count_r, count_s;
    logic            ovf_r, ovf_s;
    logic            full_r, busy_r;
    logic            push_s, pop_s, overflow_s, nonempty_s, bit_end_s;
    logic [7:0]      head_s;
    logic [7:0]      count_ext_s;

    // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a write.
    assign push_s      = wr_en && (count_r != DEPTH_N);
    assign overflow_s  = wr_en && (count_r == DEPTH_N);
    assign nonempty_s  = (count_r != {NW{1'b0}});
    assign bit_end_s   = (baud_r == BAUD_LAST);
    assign head_s      = mem_r[rd_ptr_r];
    assign count_ext_s = 8'(count_r);
    assign status      = {21'd0, ovf_r, full_r, busy_r, count_ext_s};

    // Serializer next-state, pop request and next line level.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        pop_s   = 1'b0;
        tx_s    = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (nonempty_s) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    baud_s  = {CW{1'b0}};
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_s  = {CW{1'b0}};
                    bit_s   = 3'd0;
                    state_s = ST_DATA;
                end else begin
                    baud_s = baud_r + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_s  = {CW{1'b0}};
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_s = {CW{1'b0}};
                    if (nonempty_s) begin
                        pop_s   = 1'b1;
                        shift_s = head_s;
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    baud_s = baud_r + CW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = {CW{1'b0}};
            end
        endcase
        case (state_s)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_s[0];
            default:  tx_s = 1'b1;
        endcase
    end

    // FIFO occupancy and sticky overflow; a fresh overflow beats a same-edge clear.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + NW'(1);
            2'b01:   count_s = count_r - NW'(1);
            default: count_s = count_r;
        endcase
        if (overflow_s) begin
            ovf_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // Serializer state, line level and registered status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            baud_r  <= {CW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            tx      <= 1'b1;
            busy_r  <= 1'b0;
            full_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx      <= tx_s;
            busy_r  <= (state_s != ST_IDLE);
            full_r  <= (count_s == DEPTH_N);
        end
    end

    // FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {NW{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_s;
            ovf_r   <= ovf_s;
        end
    end

    // FIFO storage; cleared on reset so queued bytes are discarded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at DIV=4, FIFO_DEPTH=4: per-cycle vector tables plus a line receiver.
module tb_uart_tx_mmio;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        clr_ovf = 1'b0;
    logic [31:0] status;
    logic        tx;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        wr_en;
        logic [7:0]  wr_data;
        logic        clr_ovf;
        logic        exp_tx;
        logic [31:0] exp_status;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_rx[$];

    logic       mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh = 8'h00;
    int         framing_errs = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(.CLOCK_RATE(40), .BAUD_RATE(10), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .status(status), .tx(tx)
    );

    // Line receiver: k=0 is the first low cycle; bits sampled mid-cell, stop bit at k=38.
    always @(negedge clk) begin
        if (!rstn) begin
            mon_act <= 1'b0;
            mon_cnt <= 0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt % 4) == 2)
                mon_sh <= {tx, mon_sh[7:1]};
            if (mon_cnt == 38) begin
                if (tx !== 1'b1) framing_errs <= framing_errs + 1;
                rx_q.push_back(mon_sh);
                mon_act <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Expected line level k cycles after the start bit begins.
    function automatic logic frame_tx(input logic [7:0] b, input int k);
        if (k < 4) return 1'b0;
        else if (k < 36) return b[(k - 4) / 4];
        else return 1'b1;
    endfunction

    task automatic add_vec(input logic w, input logic [7:0] d, input logic c,
                           input logic t, input logic [31:0] s);
        vec_t v;
        v.wr_en = w; v.wr_data = d; v.clr_ovf = c; v.exp_tx = t; v.exp_status = s;
        vq.push_back(v);
    endtask

    task automatic run_vecs(input string name);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            wr_en = vq[i].wr_en;
            wr_data = vq[i].wr_data;
            clr_ovf = vq[i].clr_ovf;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d].tx", name, i), {31'd0, tx}, {31'd0, vq[i].exp_tx});
            check($sformatf("%s[%0d].status", name, i), status, vq[i].exp_status);
        end
        @(negedge clk);
        wr_en = 1'b0;
        clr_ovf = 1'b0;
        vq.delete();
    endtask

    initial begin
        int waited;

        // Reset values: held low for three edges, then fifty quiet cycles.
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_hold.tx", {31'd0, tx}, 32'd1);
            check("rst_hold.status", status, 32'd0);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            check("rst_idle.tx", {31'd0, tx}, 32'd1);
            check("rst_idle.status", status, 32'd0);
        end

        // Single byte 0xA5: busy for exactly 40 cycles.
        add_vec(1'b1, 8'hA5, 1'b0, 1'b1, 32'h0000_0001);
        for (int i = 1; i <= 40; i++) add_vec(1'b0, 8'h00, 1'b0, frame_tx(8'hA5, i - 1), 32'h0000_0100);
        for (int i = 41; i <= 44; i++) add_vec(1'b0, 8'h00, 1'b0, 1'b1, 32'h0000_0000);
        run_vecs("single");
        exp_rx.push_back(8'hA5);

        // Back-to-back 0x00, 0xFF: second start bit directly follows the first stop bit.
        add_vec(1'b1, 8'h00, 1'b0, 1'b1, 32'h0000_0001);
        add_vec(1'b1, 8'hFF, 1'b0, frame_tx(8'h00, 0), 32'h0000_0101);
        for (int i = 2; i <= 40; i++) add_vec(1'b0, 8'h00, 1'b0, frame_tx(8'h00, i - 1), 32'h0000_0101);
        for (int i = 41; i <= 80; i++) add_vec(1'b0, 8'h00, 1'b0, frame_tx(8'hFF, i - 41), 32'h0000_0100);
        add_vec(1'b0, 8'h00, 1'b0, 1'b1, 32'h0000_0000);
        run_vecs("b2b");
        exp_rx.push_back(8'h00);
        exp_rx.push_back(8'hFF);

        // Overflow, clear, then clear colliding with a dropped write.
        add_vec(1'b1, 8'h01, 1'b0, 1'b1, 32'h0000_0001);
        add_vec(1'b1, 8'h02, 1'b0, frame_tx(8'h01, 0), 32'h0000_0101);
        add_vec(1'b1, 8'h03, 1'b0, frame_tx(8'h01, 1), 32'h0000_0102);
        add_vec(1'b1, 8'h04, 1'b0, frame_tx(8'h01, 2), 32'h0000_0103);
        add_vec(1'b1, 8'h05, 1'b0, frame_tx(8'h01, 3), 32'h0000_0304);
        add_vec(1'b1, 8'h06, 1'b0, frame_tx(8'h01, 4), 32'h0000_0704);
        add_vec(1'b0, 8'h00, 1'b0, frame_tx(8'h01, 5), 32'h0000_0704);
        add_vec(1'b0, 8'h00, 1'b1, frame_tx(8'h01, 6), 32'h0000_0304);
        add_vec(1'b0, 8'h00, 1'b0, frame_tx(8'h01, 7), 32'h0000_0304);
        add_vec(1'b1, 8'h07, 1'b1, frame_tx(8'h01, 8), 32'h0000_0704);
        add_vec(1'b0, 8'h00, 1'b1, frame_tx(8'h01, 9), 32'h0000_0304);
        run_vecs("ovf");
        for (int b = 1; b <= 5; b++) exp_rx.push_back(8'(b));

        waited = 0;
        while (status !== 32'd0 && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ovf.drain_status", status, 32'd0);
        check("ovf.rx_count", rx_q.size(), 32'd8);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h3C;
        @(negedge clk); wr_data = 8'h11;
        @(negedge clk); wr_data = 8'h22;
        @(negedge clk); wr_en = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midrst.pre_status", status, 32'h0000_0102);
        check("midrst.pre_tx", {31'd0, tx}, {31'd0, frame_tx(8'h3C, 17)});
        rstn = 1'b0;
        #1;
        check("midrst.tx_now", {31'd0, tx}, 32'd1);
        check("midrst.status_now", status, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (60) begin
            @(posedge clk); #1;
            check("midrst.after_tx", {31'd0, tx}, 32'd1);
            check("midrst.after_status", status, 32'd0);
        end

        // Everything seen on the line, in order.
        check("rx.total", rx_q.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size(); i++) begin
            if (i < rx_q.size())
                check($sformatf("rx.byte[%0d]", i), {24'd0, rx_q[i]}, {24'd0, exp_rx[i]});
        end
        check("rx.framing", framing_errs, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
